mem_access_unit: RTL
====================

# mem_access_unit

Data-memory access stage for the multi-cycle LoongArch core. It accepts one load/store request from the execute step, drives the synchronous data SRAM, and returns a register-ready result to write-back. It performs:
- byte-enable generation and store-data lane replication;
- load lane extraction with sign or zero extension;
- alignment checking.

One request is in flight at a time, with valid/ready handshakes on both sides.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  core clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request.
- req_op  in  4  operation encoding:
  - [3]: 1 = store.
  - [2]: 1 = unsigned load.
  - [1:0]: size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- req_addr  in  32  byte address (ALU result).
- req_wdata  in  32  store data (rkd value).
- req_dest  in  5  destination register number, passed through unchanged.
- resp_valid  out  1  response present.
- resp_ready  in  1  write-back accepts the response.
- resp_data  out  32  extended load data; 0 for stores and faults.
- resp_dest  out  5  registered req_dest.
- resp_is_load  out  1  response belongs to a load (write-back should write the RF).
- resp_ale  out  1  address-misalignment fault; no memory access was made.
- data_sram_en  out  1  SRAM access enable.
- data_sram_we  out  4  byte write enables.
- data_sram_addr  out  32  word-aligned address {addr[31:2], 2'b00}.
- data_sram_wdata  out  32  lane-replicated store data.
- data_sram_rdata  in  32  read data, valid one cycle after the enabled read.

## Operation
States: IDLE, ACCESS, WAIT, RESP.

Request acceptance:
- req_ready = (state == IDLE) & ~reset.
- On req_valid & req_ready, latch op, addr, wdata and dest.

Misalignment rule:
- Half access with addr[0] = 1 is misaligned.
- Word access with addr[1:0] ≠ 0 is misaligned.

Transitions:
- IDLE → RESP on accept of a misaligned request. resp_ale = 1, resp_data = 0, no SRAM activity.
- IDLE → ACCESS on accept of an aligned request.
- ACCESS:
  - Drive data_sram_en = 1, the aligned address, byte enables and wdata.
  - Store → RESP.
  - Load → WAIT.
- WAIT (load only): capture data_sram_rdata, extract and extend it into resp_data → RESP.
- RESP: resp_valid = 1. On resp_ready → IDLE. Otherwise hold, with all resp_* outputs stable.

Byte enables (stores only; loads drive 4'b0000):
- Byte: 4'b0001 << addr[1:0].
- Half: 4'b0011 << addr[1:0].
- Word: 4'b1111.

Store data:
- Byte: {4{wdata[7:0]}}.
- Half: {2{wdata[15:0]}}.
- Word: wdata.

Load extraction:
- Byte: rdata[8·addr[1:0] +: 8].
- Half: rdata[16·addr[1] +: 16].
- Extension: sign-extend when op[2] = 0, zero-extend when op[2] = 1. For words op[2] is ignored.

Outputs outside ACCESS:
- data_sram_en, data_sram_we and data_sram_wdata are 0.
- data_sram_addr holds the latched aligned address.

## Timing
- Request accepted at edge T. Response presented:
  - Misaligned: resp_valid from T+1.
  - Store: SRAM write in cycle T+1; resp_valid from T+2.
  - Load: SRAM read in T+1, data captured at end of T+2; resp_valid from T+3.
- After the resp handshake edge, req_ready = 1 the following cycle. No same-cycle request accept while in RESP.
- req_valid while the unit is not ready is ignored; the requester must hold it.
- Reset values: state IDLE, and every output 0 (req_ready = 0 while reset is high, 1 the first cycle after).
- Reset mid-operation:
  - Return to IDLE and drop any pending response.
  - A store already written in ACCESS is not undone.
  - No SRAM enable is asserted in the reset cycle.

## Test plan
- st.w addr 0x1c000104, data 0xdeadbeef → in T+1: en = 1, we = 1111, addr 0x1c000104, wdata 0xdeadbeef. resp_valid at T+2, resp_is_load = 0.
- st.b addr 0x0000_0003, data 0x12345678 → we = 1000, wdata 0x78787878. st.h addr 0x2, data 0xabcd → we = 1100, wdata 0xabcdabcd.
- Memory word 0x80ff7f01:
  - ld.b @0x1 → 0x0000007f.
  - ld.b @0x2 → 0xffffffff.
  - ld.bu @0x3 → 0x00000080.
  - ld.h @0x2 → 0xffff80ff.
  - ld.hu @0x2 → 0x000080ff.
  - Each with resp_valid at T+3 and resp_dest echoed.
- ld.w @0x6 and ld.h @0x1 → resp_ale = 1 at T+1, resp_data = 0, data_sram_en never asserted.
- Hold resp_ready = 0 for 5 cycles in RESP → resp_* stable, req_ready = 0. Assert resp_ready → IDLE, new request accepted the next cycle.
- Reset asserted during WAIT of a load → no resp_valid; after reset, all outputs 0 and req_ready = 1.

Source files
------------

// File: rtl/mem_access_unit.sv
// Data-memory access stage: one load/store in flight, drives the synchronous data SRAM
// and returns an extended, register-ready result (or an alignment fault) to write-back.
module mem_access_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_dest,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_dest,
  output logic        resp_is_load,
  output logic        resp_ale,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 4;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  logic [OP_W-1:0]     r_op;
  logic [DATA_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [BE_W-1:0]     r_we;
  logic [DATA_W-1:0]   r_resp_data;
  logic [REG_W-1:0]    r_resp_dest;
  logic                r_resp_is_load;
  logic                r_resp_ale;

  logic                w_misaligned;
  logic [BE_W-1:0]     w_we;
  logic [DATA_W-1:0]   w_wdata;
  logic [7:0]          w_byte;
  logic [15:0]         w_half;
  logic [DATA_W-1:0]   w_load_data;
  logic                w_access;

  // Request decode: alignment, byte enables and lane-replicated store data.
  always_comb begin
    w_misaligned = 1'b0;
    w_we         = '0;
    w_wdata      = '0;
    case (req_op[1:0])
      2'b00: begin
        w_we    = 4'b0001 << req_addr[1:0];
        w_wdata = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        w_misaligned = req_addr[0];
        w_we         = 4'b0011 << req_addr[1:0];
        w_wdata      = {2{req_wdata[15:0]}};
      end
      default: begin
        w_misaligned = |req_addr[1:0];
        w_we         = 4'b1111;
        w_wdata      = req_wdata;
      end
    endcase
    if (!req_op[3]) begin
      w_we    = '0;
      w_wdata = '0;
    end
  end

  // Load lane extraction and sign/zero extension of the returned SRAM word.
  always_comb begin
    w_byte = data_sram_rdata[7:0];
    case (r_addr[1:0])
      2'b01:   w_byte = data_sram_rdata[15:8];
      2'b10:   w_byte = data_sram_rdata[23:16];
      2'b11:   w_byte = data_sram_rdata[31:24];
      default: w_byte = data_sram_rdata[7:0];
    endcase
    w_half = r_addr[1] ? data_sram_rdata[31:16] : data_sram_rdata[15:0];
    case (r_op[1:0])
      2'b00:   w_load_data = r_op[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load_data = r_op[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load_data = data_sram_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_op           <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_we           <= '0;
      r_resp_data    <= '0;
      r_resp_dest    <= '0;
      r_resp_is_load <= 1'b0;
      r_resp_ale     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op           <= req_op;
            r_addr         <= req_addr;
            r_we           <= w_misaligned ? '0 : w_we;
            r_wdata        <= w_misaligned ? '0 : w_wdata;
            r_resp_data    <= '0;
            r_resp_dest    <= req_dest;
            r_resp_is_load <= ~req_op[3];
            r_resp_ale     <= w_misaligned;
            r_state        <= w_misaligned ? S_RESP : S_ACCESS;
          end
        end
        S_ACCESS: r_state <= r_op[3] ? S_RESP : S_WAIT;
        S_WAIT: begin
          r_resp_data <= w_load_data;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (resp_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // SRAM strobes exist only in ACCESS and are suppressed while reset is asserted.
  assign w_access        = (r_state == S_ACCESS) & ~reset;
  assign req_ready       = (r_state == S_IDLE) & ~reset;
  assign resp_valid      = (r_state == S_RESP);
  assign resp_data       = r_resp_data;
  assign resp_dest       = r_resp_dest;
  assign resp_is_load    = r_resp_is_load;
  assign resp_ale        = r_resp_ale;
  assign data_sram_en    = w_access;
  assign data_sram_we    = w_access ? r_we : '0;
  assign data_sram_wdata = w_access ? r_wdata : '0;
  assign data_sram_addr  = {r_addr[31:2], 2'b00};

endmodule
